// File: rtl/csr_wport_arb_if.sv
// Bundles the WB-stage write request, trap sequencer burst and CSR-file write port.
interface csr_wport_arb_if;
  logic        wb_we_i;
  logic [11:0] wb_addr_i;
  logic [31:0] wb_wdata_i;
  logic        wb_ready_o;
  logic        trap_req_i;
  logic        trap_we_i;
  logic [11:0] trap_addr_i;
  logic [31:0] trap_wdata_i;
  logic        trap_gnt_o;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;

  modport slave (
    input  wb_we_i, wb_addr_i, wb_wdata_i,
    input  trap_req_i, trap_we_i, trap_addr_i, trap_wdata_i,
    output wb_ready_o, trap_gnt_o, csr_we_o, csr_waddr_o, csr_wdata_o
  );

  modport master (
    output wb_we_i, wb_addr_i, wb_wdata_i,
    output trap_req_i, trap_we_i, trap_addr_i, trap_wdata_i,
    input  wb_ready_o, trap_gnt_o, csr_we_o, csr_waddr_o, csr_wdata_o
  );
endinterface

// File: rtl/csr_wport_arb.sv
// Arbitrates the single CSR-file write port between queued WB-stage CSR writes
// and the trap sequencer. Pending WB writes always drain before the trap burst.
module csr_wport_arb #(
  parameter int FIFO_DEPTH     = 2,
  parameter int TRAP_MAX_BEATS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  csr_wport_arb_if.slave                bus,
  output logic                          stall_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
  output logic                          err_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(TRAP_MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, TRAP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            err_q, err_d;
  logic [43:0]     mem_q [FIFO_DEPTH];

  logic            empty, full, push, pop;
  logic            wb_ready, gnt, we;
  logic [11:0]     waddr;
  logic [31:0]     wdata;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(FIFO_DEPTH));

  // Control state; reset discards any queued writes by clearing the pointers/count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
    end
  end

  // Queue storage: {addr, data} written at the tail on every accepted WB write.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.wb_addr_i, bus.wb_wdata_i};
    end
  end

  // Next-state, queue pointers, write-port mux and error detection.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    err_d    = err_q;
    wb_ready = 1'b0;
    gnt      = 1'b0;
    we       = 1'b0;
    waddr    = '0;
    wdata    = '0;
    pop      = 1'b0;
    push     = 1'b0;

    case (state_q)
      IDLE: begin
        // A rising trap request closes the WB port in the same cycle.
        wb_ready = !full && !bus.trap_req_i;
        pop      = !empty;
        if (bus.trap_req_i) begin
          state_d = empty ? TRAP : DRAIN;
        end
      end
      DRAIN: begin
        pop = !empty;
        // Hand over once the queue is (or is about to be) empty.
        if (cnt_q <= CW'(1)) begin
          state_d = TRAP;
        end
      end
      TRAP: begin
        gnt   = 1'b1;
        waddr = bus.trap_addr_i;
        wdata = bus.trap_wdata_i;
        if (!bus.trap_req_i) begin
          state_d = IDLE;
        end else if (beat_q == BW'(TRAP_MAX_BEATS)) begin
          // Sequencer overstayed its budget: revoke the port and flag it.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          we     = bus.trap_we_i;
          beat_d = beat_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      we            = 1'b1;
      {waddr, wdata} = mem_q[rd_ptr_q];
      rd_ptr_d      = rd_ptr_q + PW'(1);
    end

    if (!rst) begin
      wb_ready = 1'b0;
      gnt      = 1'b0;
      we       = 1'b0;
      waddr    = '0;
      wdata    = '0;
    end

    push = bus.wb_we_i && wb_ready;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (state_q != TRAP && state_d == TRAP) begin
      beat_d = '0;
    end

    if (bus.wb_we_i && !wb_ready) begin
      err_d = 1'b1;
    end
    if (bus.trap_we_i && !gnt) begin
      err_d = 1'b1;
    end
  end

  assign bus.wb_ready_o  = wb_ready;
  assign bus.trap_gnt_o  = gnt;
  assign bus.csr_we_o    = we;
  assign bus.csr_waddr_o = waddr;
  assign bus.csr_wdata_o = wdata;
  assign stall_o         = !wb_ready;
  assign fifo_cnt_o      = cnt_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_csr_wport_arb.sv
// Bench for csr_wport_arb: cycle vectors with expected control outputs, plus a
// scoreboard of expected CSR writes (address/data/order).
module tb_csr_wport_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stall;
  logic [1:0] fifo_cnt;
  logic       err;

  csr_wport_arb_if bus ();

  csr_wport_arb #(.FIFO_DEPTH(2), .TRAP_MAX_BEATS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .stall_o    (stall),
    .fifo_cnt_o (fifo_cnt),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb_we;
    logic [11:0] wb_addr;
    logic [31:0] wb_data;
    logic        trq;
    logic        twe;
    logic [11:0] taddr;
    logic [31:0] tdata;
    logic        e_ready;
    logic        e_gnt;
    logic        e_we;
    logic [1:0]  e_cnt;
    logic        e_err;
  } vec_t;

  vec_t        tbl[$];
  logic [43:0] sb[$];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic vec_t mk(logic wbwe, logic [11:0] wba, logic [31:0] wbd,
                              logic trq, logic twe, logic [11:0] ta, logic [31:0] td,
                              logic er, logic eg, logic ew, logic [1:0] ec, logic ee);
    vec_t v;
    v.wb_we = wbwe; v.wb_addr = wba; v.wb_data = wbd;
    v.trq = trq; v.twe = twe; v.taddr = ta; v.tdata = td;
    v.e_ready = er; v.e_gnt = eg; v.e_we = ew; v.e_cnt = ec; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.wb_we_i      = v.wb_we;
    bus.wb_addr_i    = v.wb_addr;
    bus.wb_wdata_i   = v.wb_data;
    bus.trap_req_i   = v.trq;
    bus.trap_we_i    = v.twe;
    bus.trap_addr_i  = v.taddr;
    bus.trap_wdata_i = v.tdata;
  endtask

  // Drive one cycle, compare at the falling edge, advance to just past the next rising edge.
  task automatic apply(vec_t v, string tag);
    drive(v);
    @(negedge clk);
    chk({tag, ".ready"}, 64'(bus.wb_ready_o), 64'(v.e_ready));
    chk({tag, ".stall"}, 64'(stall), 64'(!v.e_ready));
    chk({tag, ".gnt"},   64'(bus.trap_gnt_o), 64'(v.e_gnt));
    chk({tag, ".we"},    64'(bus.csr_we_o), 64'(v.e_we));
    chk({tag, ".cnt"},   64'(fifo_cnt), 64'(v.e_cnt));
    chk({tag, ".err"},   64'(err), 64'(v.e_err));
    if (!v.e_gnt && !v.e_we)
      chk({tag, ".idle_bus"}, 64'({bus.csr_waddr_o, bus.csr_wdata_o}), 64'(0));
    if (v.e_gnt && v.e_we && v.trq && v.twe)
      sb.push_back({v.taddr, v.tdata});
    if (bus.csr_we_o) begin
      if (sb.size() == 0) begin
        chk({tag, ".sb_unexpected_write"}, 64'({bus.csr_waddr_o, bus.csr_wdata_o}), 64'(0));
      end else begin
        chk({tag, ".sb_write"}, 64'({bus.csr_waddr_o, bus.csr_wdata_o}), 64'(sb.pop_front()));
      end
    end
    if (v.wb_we && v.e_ready)
      sb.push_back({v.wb_addr, v.wb_data});
    @(posedge clk);
    #1;
  endtask

  // Assert reset asynchronously (inputs left as they are), check the reset outputs,
  // then release just after a rising edge.
  task automatic do_reset(string tag);
    rst = 1'b0;
    #2;
    chk({tag, ".rst_we"},    64'(bus.csr_we_o), 64'(0));
    chk({tag, ".rst_bus"},   64'({bus.csr_waddr_o, bus.csr_wdata_o}), 64'(0));
    chk({tag, ".rst_gnt"},   64'(bus.trap_gnt_o), 64'(0));
    chk({tag, ".rst_ready"}, 64'(bus.wb_ready_o), 64'(0));
    chk({tag, ".rst_stall"}, 64'(stall), 64'(1));
    chk({tag, ".rst_cnt"},   64'(fifo_cnt), 64'(0));
    chk({tag, ".rst_err"},   64'(err), 64'(0));
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Single write, back-to-back writes, drain-then-trap, direct trap, overrun.
    tbl.push_back(mk(1, 12'h305, 32'h8000_0000, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,                  1, 0, 1, 1, 0));
    tbl.push_back(idle);
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 12'h100 + 12'(i), 32'hA5A5_0000 + 32'(i), 0, 0, 0, 0,
                       1, 0, (i != 0), (i != 0) ? 2'd1 : 2'd0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
    tbl.push_back(idle);
    tbl.push_back(mk(1, 12'h340, 32'h0000_1111, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 12'h341, 32'h0000_2222, 0, 0, 0, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 12'h341, 32'hDEAD_0001, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 12'h342, 32'hDEAD_0002, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 12'h343, 32'hDEAD_0003, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 12'h300, 32'hDEAD_0004, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 12'h3FF, 32'hFFFF_FFFF, 0, 1, 0, 0, 0));
    tbl.push_back(idle);
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 12'h123, 32'h1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(idle);
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 0, 0, 1, 1, 12'h7A0 + 12'(i), 32'hBEEF_0000 + 32'(i), 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 12'h7A8, 32'hBEEF_0008, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));

    @(posedge clk);
    #1;
    do_reset("por");
    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    // Reset with a write still queued: it must be discarded.
    drive(mk(1, 12'h222, 32'h2222_2222, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("q.ready", 64'(bus.wb_ready_o), 64'(1));
    @(posedge clk);
    #1;
    chk("q.cnt", 64'(fifo_cnt), 64'(1));
    do_reset("q");
    apply(idle, "q.after");
    apply(idle, "q.after2");

    // Reset in the middle of a trap burst with the beat still being driven.
    apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "t.enter");
    apply(mk(0, 0, 0, 1, 1, 12'h7FF, 32'h0BAD_F00D, 0, 1, 1, 0, 0), "t.beat");
    drive(mk(0, 0, 0, 1, 1, 12'h7FE, 32'h0BAD_F00E, 0, 0, 0, 0, 0));
    do_reset("t");
    apply(idle, "t.after");

    // Trap write while not granted: dropped, sticky error.
    apply(mk(0, 0, 0, 0, 1, 12'h456, 32'h4567, 1, 0, 0, 0, 0), "e1.twe");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), "e1.flag");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), "e1.sticky");
    do_reset("e2");

    // WB write during the trap burst: dropped, sticky error.
    apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "e2.enter");
    apply(mk(1, 12'h123, 32'h1234, 1, 0, 0, 0, 0, 1, 0, 0, 0), "e2.wbwe");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1), "e2.exit");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), "e2.idle");

    chk("sb.leftover", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
